dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port, the loader port and the data-memory port of the arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) ();

    // Core requester
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_rvalid;

    // Loader requester
    logic          l_req;
    logic          l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt;
    logic          l_rvalid;

    // Shared registered read data
    logic [DW-1:0] rdata;

    // Data memory side
    logic          m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    // Requester side (core + loader)
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        input  c_gnt, c_rvalid, l_gnt, l_rvalid, rdata
    );

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, l_gnt, l_rvalid, rdata,
        output m_wr_en, m_addr, m_wdata
    );

    // Memory side
    modport mem (
        input  m_wr_en, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core and the loader share one memory port.
// Ownership is held in a registered state; an owner keeps the port while it requests,
// but is limited to MAXB consecutive transfers while the other port is waiting.
module dmem_arbiter #(
    parameter int unsigned AW   = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned MAXB = 4
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    localparam int unsigned    CntW   = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAXB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCore,
        StLoad
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            last_core_q, last_core_d;  // 1: core was served last, 0: loader
    logic            c_rvalid_q, c_rvalid_d;
    logic            l_rvalid_q, l_rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            c_gnt, l_gnt;
    logic            c_xfer, l_xfer;
    logic            own_req, oth_req;
    state_e          oth_state;
    logic            m_wr_en;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;

    // Grants come straight from the state register, so they are glitch-free and exclusive.
    assign c_gnt  = (state_q == StCore);
    assign l_gnt  = (state_q == StLoad);
    assign c_xfer = c_gnt & bus.c_req;
    assign l_xfer = l_gnt & bus.l_req;

    // Owner-relative view of the requests so both owner states share one rule set.
    always_comb begin
        own_req   = 1'b0;
        oth_req   = 1'b0;
        oth_state = StIdle;
        if (c_gnt) begin
            own_req   = bus.c_req;
            oth_req   = bus.l_req;
            oth_state = StLoad;
        end else if (l_gnt) begin
            own_req   = bus.l_req;
            oth_req   = bus.c_req;
            oth_state = StCore;
        end
    end

    // Next ownership and burst counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.c_req && bus.l_req) begin
                    state_d = last_core_q ? StLoad : StCore;
                end else if (bus.c_req) begin
                    state_d = StCore;
                end else if (bus.l_req) begin
                    state_d = StLoad;
                end
            end
            StCore, StLoad: begin
                if (own_req) begin
                    if (oth_req && (cnt_q == CntMax)) begin
                        // Burst budget used up while the other side waits.
                        state_d = oth_state;
                        cnt_d   = '0;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Owner released: hand over directly or fall back to idle.
                    cnt_d   = '0;
                    state_d = oth_req ? oth_state : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Fairness memory, read-valid strobes and read-data capture.
    always_comb begin
        last_core_d = last_core_q;
        if (c_xfer) begin
            last_core_d = 1'b1;
        end else if (l_xfer) begin
            last_core_d = 1'b0;
        end
        c_rvalid_d = c_xfer & ~bus.c_we;
        l_rvalid_d = l_xfer & ~bus.l_we;
        rdata_d    = rdata_q;
        if (c_rvalid_d || l_rvalid_d) begin
            rdata_d = bus.m_rdata;
        end
    end

    // Memory port follows the granted requester; no owner drives zeros.
    always_comb begin
        m_wr_en = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_wr_en = bus.c_req & bus.c_we;
            m_addr  = bus.c_addr;
            m_wdata = bus.c_wdata;
        end else if (l_gnt) begin
            m_wr_en = bus.l_req & bus.l_we;
            m_addr  = bus.l_addr;
            m_wdata = bus.l_wdata;
        end
    end

    // State registers with synchronous reset; reset discards any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_core_q <= 1'b0;
            c_rvalid_q  <= 1'b0;
            l_rvalid_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_core_q <= last_core_d;
            c_rvalid_q  <= c_rvalid_d;
            l_rvalid_q  <= l_rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.l_gnt    = l_gnt;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.l_rvalid = l_rvalid_q;
    assign bus.rdata    = rdata_q;
    assign bus.m_wr_en  = m_wr_en;
    assign bus.m_addr   = m_addr;
    assign bus.m_wdata  = m_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: read results are checked through a scoreboard queue,
// grants and memory-port signals are checked cycle by cycle.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus0 ();
    dmem_arbiter_if #(.AW(8), .DW(8)) bus1 ();

    dmem_arbiter #(.AW(8), .DW(8), .MAXB(4)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    dmem_arbiter #(.AW(8), .DW(8), .MAXB(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Data memory model (written by dut0) and the bench's own expected contents.
    logic [7:0] mem     [256];
    logic [7:0] exp_mem [256];

    assign bus0.m_rdata = mem[bus0.m_addr];
    assign bus1.m_rdata = mem[bus1.m_addr];

    always @(posedge clk) begin
        if (bus0.m_wr_en === 1'b1) mem[bus0.m_addr] <= bus0.m_wdata;
    end

    typedef struct {
        bit         core;
        logic [7:0] data;
    } sb_t;

    sb_t sb_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit core, input logic [7:0] addr);
        sb_t e;
        e.core = core;
        e.data = exp_mem[addr];
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus0.c_req = 0; bus0.c_we = 0; bus0.c_addr = 0; bus0.c_wdata = 0;
        bus0.l_req = 0; bus0.l_we = 0; bus0.l_addr = 0; bus0.l_wdata = 0;
        bus1.c_req = 0; bus1.c_we = 0; bus1.c_addr = 0; bus1.c_wdata = 0;
        bus1.l_req = 0; bus1.l_we = 0; bus1.l_addr = 0; bus1.l_wdata = 0;
    endtask

    // Scoreboard consumer: every read-valid must match the oldest expected read.
    always @(negedge clk) begin
        if (bus0.c_rvalid === 1'b1 || bus0.l_rvalid === 1'b1) begin
            chk("rv_pending", 32'(sb_q.size() != 0), 1);
            chk("rv_both", 32'(bus0.c_rvalid & bus0.l_rvalid), 0);
            if (sb_q.size() != 0) begin
                sb_t e;
                e = sb_q.pop_front();
                chk("rv_port", 32'(bus0.c_rvalid), 32'(e.core));
                chk("rv_data", 32'(bus0.rdata), 32'(e.data));
            end
        end
    end

    initial begin
        bit ec, el;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            exp_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[8'h10]     = 8'hA5;
        exp_mem[8'h10] = 8'hA5;

        // Reset with random inputs: everything held at zero.
        idle_inputs();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus0.c_req = 1'($urandom); bus0.c_we = 1'($urandom);
            bus0.c_addr = 8'($urandom); bus0.c_wdata = 8'($urandom);
            bus0.l_req = 1'($urandom); bus0.l_we = 1'($urandom);
            bus0.l_addr = 8'($urandom); bus0.l_wdata = 8'($urandom);
            neg();
            chk("rst_c_gnt", 32'(bus0.c_gnt), 0);
            chk("rst_l_gnt", 32'(bus0.l_gnt), 0);
            chk("rst_c_rvalid", 32'(bus0.c_rvalid), 0);
            chk("rst_l_rvalid", 32'(bus0.l_rvalid), 0);
            chk("rst_rdata", 32'(bus0.rdata), 0);
            chk("rst_m_wr_en", 32'(bus0.m_wr_en), 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        // Core-only read of 0x10.
        bus0.c_req = 1; bus0.c_addr = 8'h10;
        neg(); chk("b_gnt_latency", 32'(bus0.c_gnt), 0); tick();
        push(1, 8'h10);
        neg();
        chk("b_c_gnt", 32'(bus0.c_gnt), 1);
        chk("b_l_gnt", 32'(bus0.l_gnt), 0);
        chk("b_m_addr", 32'(bus0.m_addr), 32'h10);
        chk("b_m_wr_en", 32'(bus0.m_wr_en), 0);
        tick();
        bus0.c_req = 0;
        neg();
        chk("b_c_rvalid", 32'(bus0.c_rvalid), 1);
        chk("b_rdata", 32'(bus0.rdata), 32'hA5);
        chk("b_l_rvalid", 32'(bus0.l_rvalid), 0);
        tick();
        neg();
        chk("b_idle_gnt", 32'(bus0.c_gnt), 0);
        chk("b_rvalid_once", 32'(bus0.c_rvalid), 0);
        chk("b_idle_m_addr", 32'(bus0.m_addr), 0);
        tick();

        // Continuous contention from a fresh reset: 4 core, 4 loader, 4 core.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            bus0.c_req = 1; bus0.c_addr = 8'(8'h40 + k);
            bus0.l_req = 1; bus0.l_addr = 8'(8'h60 + k);
            ec = (k >= 1 && k <= 4) || (k >= 9 && k <= 12);
            el = (k >= 5 && k <= 8);
            if (ec) push(1, bus0.c_addr);
            if (el) push(0, bus0.l_addr);
            neg();
            chk($sformatf("c_burst_c_gnt_%0d", k), 32'(bus0.c_gnt), 32'(ec));
            chk($sformatf("c_burst_l_gnt_%0d", k), 32'(bus0.l_gnt), 32'(el));
            chk("c_no_overlap", 32'(bus0.c_gnt & bus0.l_gnt), 0);
            tick();
        end
        idle_inputs();
        neg(); tick();
        neg(); tick();

        // Loader writes 0x01..0x03 to 0x20..0x22, then releases.
        bus0.l_req = 1; bus0.l_we = 1; bus0.l_addr = 8'h20; bus0.l_wdata = 8'h01;
        neg(); chk("d_gnt_latency", 32'(bus0.l_gnt), 0); tick();
        for (int k = 1; k <= 3; k++) begin
            bus0.l_addr = 8'(8'h1F + k); bus0.l_wdata = 8'(k);
            exp_mem[bus0.l_addr] = 8'(k);
            neg();
            chk($sformatf("d_l_gnt_%0d", k), 32'(bus0.l_gnt), 1);
            chk($sformatf("d_m_wr_en_%0d", k), 32'(bus0.m_wr_en), 1);
            chk($sformatf("d_m_addr_%0d", k), 32'(bus0.m_addr), 32'(8'h1F + k));
            chk($sformatf("d_m_wdata_%0d", k), 32'(bus0.m_wdata), 32'(k));
            tick();
        end
        bus0.l_req = 0;
        neg();
        chk("d_release_wr_en", 32'(bus0.m_wr_en), 0);
        chk("d_release_gnt", 32'(bus0.l_gnt), 1);
        tick();
        neg();
        chk("d_idle_l_gnt", 32'(bus0.l_gnt), 0);
        chk("d_idle_c_gnt", 32'(bus0.c_gnt), 0);
        tick();
        // Read one written word back through the core.
        bus0.l_we = 0; bus0.c_req = 1; bus0.c_addr = 8'h21;
        neg(); tick();
        push(1, 8'h21);
        neg(); chk("d_rb_gnt", 32'(bus0.c_gnt), 1); tick();
        bus0.c_req = 0;
        neg(); tick();
        neg(); tick();

        // Core takes 2 transfers, loader arrives, core drops: loader gets its full budget.
        bus0.c_req = 1; bus0.c_addr = 8'h50;
        neg(); tick();
        push(1, 8'h50);
        neg(); chk("e_c_gnt_1", 32'(bus0.c_gnt), 1); tick();
        bus0.c_addr = 8'h51; push(1, 8'h51);
        neg(); chk("e_c_gnt_2", 32'(bus0.c_gnt), 1); tick();
        bus0.c_req = 0; bus0.l_req = 1; bus0.l_addr = 8'h70;
        neg();
        chk("e_drop_c_gnt", 32'(bus0.c_gnt), 1);
        chk("e_drop_l_gnt", 32'(bus0.l_gnt), 0);
        tick();
        for (int j = 0; j < 4; j++) begin
            bus0.c_req = 1; bus0.c_addr = 8'h52; bus0.l_addr = 8'(8'h70 + j);
            push(0, bus0.l_addr);
            neg();
            chk($sformatf("e_l_gnt_%0d", j), 32'(bus0.l_gnt), 1);
            chk($sformatf("e_c_wait_%0d", j), 32'(bus0.c_gnt), 0);
            tick();
        end
        push(1, 8'h52);
        neg();
        chk("e_back_c_gnt", 32'(bus0.c_gnt), 1);
        chk("e_back_l_gnt", 32'(bus0.l_gnt), 0);
        tick();
        idle_inputs();
        neg(); tick();
        neg(); tick();

        // Reset in the middle of a core read burst.
        bus0.c_req = 1; bus0.c_addr = 8'h58;
        neg(); tick();
        push(1, 8'h58);
        neg(); chk("f_c_gnt", 32'(bus0.c_gnt), 1); tick();
        bus0.c_addr = 8'h59; reset = 1'b1;
        neg(); tick();
        neg();
        chk("f_rst_c_gnt", 32'(bus0.c_gnt), 0);
        chk("f_rst_c_rvalid", 32'(bus0.c_rvalid), 0);
        chk("f_rst_rdata", 32'(bus0.rdata), 0);
        tick();
        reset = 1'b0;
        bus0.c_req = 1; bus0.c_addr = 8'h5A; bus0.l_req = 1; bus0.l_addr = 8'h7A;
        neg();
        chk("f_idle_c_gnt", 32'(bus0.c_gnt), 0);
        chk("f_idle_l_gnt", 32'(bus0.l_gnt), 0);
        tick();
        push(1, 8'h5A);
        neg();
        chk("f_first_c_gnt", 32'(bus0.c_gnt), 1);
        chk("f_first_l_gnt", 32'(bus0.l_gnt), 0);
        tick();
        idle_inputs();
        neg(); tick();
        neg(); tick();

        // MAXB = 1: strict alternation under continuous contention, core first.
        for (int k = 0; k < 8; k++) begin
            bus1.c_req = 1; bus1.c_addr = 8'(k);
            bus1.l_req = 1; bus1.l_addr = 8'(8'h80 + k);
            ec = (k % 2) == 1;
            el = (k > 0) && ((k % 2) == 0);
            neg();
            chk($sformatf("g_c_gnt_%0d", k), 32'(bus1.c_gnt), 32'(ec));
            chk($sformatf("g_l_gnt_%0d", k), 32'(bus1.l_gnt), 32'(el));
            tick();
        end
        idle_inputs();
        neg(); tick();
        neg(); tick();

        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
